multipack_unpacker: RTL and testbench
=====================================

# multipack_unpacker

Reader side of the multi-dimensional packed-array datapath: accepts one packed word of `LANES` elements of `W` bits and returns the elements on a narrow valid/ready stream. Each beat carries one lane, or two adjacent lanes taken as an ascending (`+:`) or descending (`-:`) part-select. It sits downstream of the lane packers and feeds element-serial consumers.

## Interface
- `LANES`, default 4: number of packed lanes; even, ≥2.
- `W`, default 3: element width in bits; ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  the input word is offered.
- `in_ready`  out  1  the unpacker can take a word this cycle.
- `in_data`  in  [LANES-1:0][W-1:0]  packed word; lane `i` is `in_data[i]`.
- `in_pair`  in  1  0 = one lane per beat; 1 = two lanes per beat.
- `in_desc`  in  1  0 = ascending from lane 0; 1 = descending from lane LANES-1.
- `out_valid`  out  1  a beat is presented.
- `out_ready`  in  1  the consumer takes the beat.
- `out_data`  out  [1:0][W-1:0]  beat payload.
- `out_count`  out  2  number of valid lanes in `out_data`: 1 or 2, or 0 when idle.
- `out_last`  out  1  final beat of the word.

## Operation
- Two states. IDLE: hold register empty. BUSY: a word is held.
- `in_ready` = (state==IDLE) || (out_valid && out_ready && out_last). This allows back-to-back words with no bubble.
- Accept on `in_valid && in_ready`:
  - latch `in_data`, `in_pair` and `in_desc`;
  - set index `idx` = `in_desc ? LANES-1 : 0`;
  - next state is BUSY.
- `out_valid` = (state==BUSY).
- Single mode (`pair=0`):
  - `out_data[0]` = `hold[idx]`, `out_data[1]` = 0, `out_count` = 1.
  - `idx` steps by ±1 per beat; LANES beats per word.
- Pair ascending:
  - `out_data[0]` = `hold[idx]`, `out_data[1]` = `hold[idx+1]`, so `out_data` equals `hold[idx+:2]`.
  - `idx` steps by +2; LANES/2 beats per word.
- Pair descending:
  - `out_data[1]` = `hold[idx]`, `out_data[0]` = `hold[idx-1]`, so `out_data` equals `hold[idx-:2]`.
  - `idx` steps by −2; LANES/2 beats per word.
- `out_last` is high when `idx` is the final index: LANES-1 (single ascending), 0 (single descending), LANES-2 (pair ascending) or 1 (pair descending).
- Beat transfer on `out_valid && out_ready`:
  - not last: advance `idx`;
  - last with a new word accepted in the same cycle: reload from the new word and stay BUSY;
  - last with no new word: go to IDLE and clear the hold register.
- While IDLE, `out_data`, `out_count` and `out_last` are 0.
- Index width is `$clog2(LANES)`. Step arithmetic never wraps, because `last` stops the walk first.

## Timing
- Reset values (asynchronous): state IDLE, hold register 0, `idx` 0. Outputs: `out_valid` 0, `out_data` 0, `out_count` 0, `out_last` 0, `in_ready` 1.
- Latency: a word accepted at edge N gives `out_valid`=1 after edge N. The first beat can transfer at edge N+1.
- Throughput: one beat per cycle while `out_ready`=1. Words with `pair=1` take LANES/2 cycles; words with `pair=0` take LANES cycles.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_count` and `out_last` hold stable and `idx` does not move.
- Mode inputs are sampled only at accept. Changing `in_pair` or `in_desc` mid-word has no effect.
- Reset asserted mid-word discards the word. No partial beat is emitted after release.

## Structure
- Shared package `multipack_pkg`:
  - state enum `mp_state_e` {MP_IDLE, MP_BUSY};
  - constants `MP_CNT_SINGLE`=2'd1 and `MP_CNT_PAIR`=2'd2.
- One sub-module, `multipack_lane_sel`: combinational. Takes hold, idx, pair and desc; produces `out_data`, `out_count` and `last`.
- The sequential control (state, hold, idx) stays in the top module.

## Test plan
Defaults LANES=4, W=3. Word A lanes 0..3 = 001, 011, 100, 010.
1. Reset: `rst_n`=0 → `in_ready`=1, `out_valid`=0 and all outputs 0.
2. A, pair=0, desc=0, `out_ready`=1 → beats 001, 011, 100, 010 on `out_data[0]`, `out_count`=1, `out_last` on beat 4 only.
3. A, pair=1, desc=0 → beat0 {[1]=011,[0]=001}, beat1 {[1]=010,[0]=100} with `out_last`. Next, A, pair=1, desc=1 → beat0 {[1]=010,[0]=100}, beat1 {[1]=011,[0]=001} with `out_last`.
4. Back-to-back: A (pair=1), then word B = 110, 100, 010, 101 offered on A's last beat → B accepted that cycle. Beats follow with no idle cycle: {011,001}, {010,100}, {100,110}, {101,010}.
5. Stall: A, pair=0, `out_ready` low for 3 cycles on beat 2 → `out_data[0]` holds 011 and `in_ready`=0 throughout. The sequence then resumes with 100, 010.
6. `rst_n` pulsed low during beat 2 of A → immediately `out_valid`=0 and `in_ready`=1. Next word B (pair=0, desc=1) yields 101, 010, 100, 110.

Source files
------------

// File: rtl/multipack_pkg.sv
// Shared definitions for the multi-dimensional packed-array datapath.
//   mp_state_e     : control state of the unpacker (empty / holding a word)
//   MP_CNT_SINGLE  : out_count value for a one-lane beat
//   MP_CNT_PAIR    : out_count value for a two-lane beat
package multipack_pkg;

  typedef enum logic {
    MP_IDLE = 1'b0,
    MP_BUSY = 1'b1
  } mp_state_e;

  localparam logic [1:0] MP_CNT_SINGLE = 2'd1;
  localparam logic [1:0] MP_CNT_PAIR   = 2'd2;

endpackage : multipack_pkg

// File: rtl/multipack_lane_sel.sv
// Combinational lane selector for the unpacker.
// Picks one lane, or two adjacent lanes as an ascending (+:) or descending
// (-:) part-select, out of the held word at the current walk index, and
// flags whether that index is the final one for the word's mode.
//   hold      : held packed word, lane i is hold[i]
//   idx       : current walk index
//   pair      : 0 = one lane per beat, 1 = two lanes per beat
//   desc      : 0 = walk up from lane 0, 1 = walk down from lane LANES-1
//   out_data  : beat payload, unused upper slot is 0 in single mode
//   out_count : number of valid lanes in out_data (1 or 2)
//   last      : idx is the final index of the walk
module multipack_lane_sel
  import multipack_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 3,
  parameter int IW    = $clog2(LANES)
) (
  input  logic [LANES-1:0][W-1:0] hold,
  input  logic [IW-1:0]           idx,
  input  logic                    pair,
  input  logic                    desc,
  output logic [1:0][W-1:0]       out_data,
  output logic [1:0]              out_count,
  output logic                    last
);

  localparam logic [IW-1:0] IDX_TOP      = IW'(LANES - 1);
  localparam logic [IW-1:0] IDX_PAIR_TOP = IW'(LANES - 2);
  localparam logic [IW-1:0] IDX_ONE      = IW'(1);

  // Neighbour indices; they only leave the lane range on combinations the
  // walk never reaches, because last stops it first.
  logic [IW-1:0] idx_up;
  logic [IW-1:0] idx_dn;

  assign idx_up = idx + IDX_ONE;
  assign idx_dn = idx - IDX_ONE;

  // NOTE: every output gets a default at the top of the block, so no path
  // through the case split can leave one unassigned and infer a latch.
  always_comb begin
    out_data  = '0;
    out_count = MP_CNT_SINGLE;
    last      = 1'b0;
    if (!pair) begin
      out_data[0] = hold[idx];
      last        = desc ? (idx == '0) : (idx == IDX_TOP);
    end else if (!desc) begin
      out_data[0] = hold[idx];
      out_data[1] = hold[idx_up];
      out_count   = MP_CNT_PAIR;
      last        = (idx == IDX_PAIR_TOP);
    end else begin
      out_data[1] = hold[idx];
      out_data[0] = hold[idx_dn];
      out_count   = MP_CNT_PAIR;
      last        = (idx == IDX_ONE);
    end
  end

endmodule : multipack_lane_sel

// File: rtl/multipack_unpacker.sv
// Reader side of the packed-array datapath: takes one packed word of LANES
// elements and streams it out one lane (or one adjacent lane pair) per beat.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : a word is offered on in_data
//   in_ready    : a word can be taken this cycle (also on the last beat)
//   in_data     : packed word, lane i is in_data[i]
//   in_pair     : 0 = one lane per beat, 1 = two lanes per beat
//   in_desc     : 0 = ascending from lane 0, 1 = descending from LANES-1
//   out_valid   : a beat is presented
//   out_ready   : the consumer takes the beat
//   out_data    : beat payload
//   out_count   : valid lanes in out_data (1 or 2), 0 when idle
//   out_last    : final beat of the word
module multipack_unpacker
  import multipack_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0][W-1:0] in_data,
  input  logic                    in_pair,
  input  logic                    in_desc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0][W-1:0]       out_data,
  output logic [1:0]              out_count,
  output logic                    out_last
);

  localparam int            IW      = $clog2(LANES);
  localparam logic [IW-1:0] IDX_TOP = IW'(LANES - 1);
  localparam logic [IW-1:0] STEP1   = IW'(1);
  localparam logic [IW-1:0] STEP2   = IW'(2);

  mp_state_e               state;
  logic [LANES-1:0][W-1:0] hold;
  logic [IW-1:0]           idx;
  logic                    pair_q;
  logic                    desc_q;

  logic [1:0][W-1:0] sel_data;
  logic [1:0]        sel_count;
  logic              sel_last;
  logic              busy;
  logic              beat_fire;
  logic              accept;
  logic [IW-1:0]     step;
  logic [IW-1:0]     idx_next;

  multipack_lane_sel #(
    .LANES (LANES),
    .W     (W),
    .IW    (IW)
  ) u_lane_sel (
    .hold      (hold),
    .idx       (idx),
    .pair      (pair_q),
    .desc      (desc_q),
    .out_data  (sel_data),
    .out_count (sel_count),
    .last      (sel_last)
  );

  assign busy      = (state == MP_BUSY);
  assign beat_fire = busy && out_ready;
  // Taking the next word on the last beat keeps back-to-back words bubble-free.
  assign in_ready  = !busy || (beat_fire && sel_last);
  assign accept    = in_valid && in_ready;

  assign out_valid = busy;
  assign out_data  = busy ? sel_data  : '0;
  assign out_count = busy ? sel_count : 2'd0;
  assign out_last  = busy && sel_last;

  assign step     = pair_q ? STEP2 : STEP1;
  assign idx_next = desc_q ? (idx - step) : (idx + step);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering within the block
  // cannot change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MP_IDLE;
      // NOTE: the hold register is reset (and cleared on going idle) on
      // purpose: an empty unpacker must never expose a stale word.
      hold   <= '0;
      idx    <= '0;
      pair_q <= 1'b0;
      desc_q <= 1'b0;
    end else if (accept) begin
      state  <= MP_BUSY;
      hold   <= in_data;
      pair_q <= in_pair;
      desc_q <= in_desc;
      idx    <= in_desc ? IDX_TOP : '0;
    end else if (beat_fire) begin
      if (sel_last) begin
        state <= MP_IDLE;
        hold  <= '0;
        idx   <= '0;
      end else begin
        idx <= idx_next;
      end
    end
  end

endmodule : multipack_unpacker

// File: tb/tb_multipack_unpacker.sv
// Directed bench for multipack_unpacker at LANES=4, W=3.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_multipack_unpacker;

  localparam int LANES = 4;
  localparam int W     = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0][W-1:0] in_data;
  logic                    in_pair;
  logic                    in_desc;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0][W-1:0]       out_data;
  logic [1:0]              out_count;
  logic                    out_last;

  int n_checks = 0;
  int n_fail   = 0;

  // Lane 3 is the leftmost element of each concatenation.
  logic [LANES-1:0][W-1:0] word_a;
  logic [LANES-1:0][W-1:0] word_b;

  multipack_unpacker #(
    .LANES (LANES),
    .W     (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pair   (in_pair),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_data"},  32'(out_data),  32'd0);
    check({tag, ".out_count"}, 32'(out_count), 32'd0);
    check({tag, ".out_last"},  32'(out_last),  32'd0);
  endtask

  // Offer a word until it is taken (bounded), then withdraw it and scramble
  // the mode inputs, which must have no effect on the word in flight.
  task automatic send_word(input logic [LANES-1:0][W-1:0] d, input logic p, input logic ds);
    int n = 0;
    in_data  = d;
    in_pair  = p;
    in_desc  = ds;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("accept.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_pair  = ~p;
    in_desc  = ~ds;
  endtask

  // Expect one beat presented and transferred this cycle (out_ready high).
  task automatic beat(input string tag, input logic [W-1:0] d1, input logic [W-1:0] d0,
                      input logic [1:0] cnt, input logic last);
    @(negedge clk);
    check({tag, ".out_valid"}, 32'(out_valid),   32'd1);
    check({tag, ".d1"},        32'(out_data[1]), 32'(d1));
    check({tag, ".d0"},        32'(out_data[0]), 32'(d0));
    check({tag, ".out_count"}, 32'(out_count),   32'(cnt));
    check({tag, ".out_last"},  32'(out_last),    32'(last));
    check({tag, ".in_ready"},  32'(in_ready),    32'(last));
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_a    = {3'b010, 3'b100, 3'b011, 3'b001};
    word_b    = {3'b101, 3'b010, 3'b100, 3'b110};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_pair   = 1'b0;
    in_desc   = 1'b0;
    out_ready = 1'b1;

    // 1. Reset state
    #2;
    check_idle("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    @(posedge clk);
    #1;

    // 2. Single ascending
    send_word(word_a, 1'b0, 1'b0);
    beat("sa0", 3'b000, 3'b001, 2'd1, 1'b0);
    beat("sa1", 3'b000, 3'b011, 2'd1, 1'b0);
    beat("sa2", 3'b000, 3'b100, 2'd1, 1'b0);
    beat("sa3", 3'b000, 3'b010, 2'd1, 1'b1);
    @(negedge clk);
    check_idle("sa_done");
    @(posedge clk);
    #1;

    // 3. Pair ascending, then pair descending
    send_word(word_a, 1'b1, 1'b0);
    beat("pa0", 3'b011, 3'b001, 2'd2, 1'b0);
    beat("pa1", 3'b010, 3'b100, 2'd2, 1'b1);
    @(negedge clk);
    check_idle("pa_done");
    @(posedge clk);
    #1;
    send_word(word_a, 1'b1, 1'b1);
    beat("pd0", 3'b010, 3'b100, 2'd2, 1'b0);
    beat("pd1", 3'b011, 3'b001, 2'd2, 1'b1);
    @(negedge clk);
    check_idle("pd_done");
    @(posedge clk);
    #1;

    // 4. Back-to-back: B offered on A's last beat
    send_word(word_a, 1'b1, 1'b0);
    beat("bb0", 3'b011, 3'b001, 2'd2, 1'b0);
    in_data  = word_b;
    in_pair  = 1'b1;
    in_desc  = 1'b0;
    in_valid = 1'b1;
    beat("bb1", 3'b010, 3'b100, 2'd2, 1'b1);
    in_valid = 1'b0;
    in_data  = '0;
    beat("bb2", 3'b100, 3'b110, 2'd2, 1'b0);
    beat("bb3", 3'b101, 3'b010, 2'd2, 1'b1);
    @(negedge clk);
    check_idle("bb_done");
    @(posedge clk);
    #1;

    // 5. Stall on beat 2
    send_word(word_a, 1'b0, 1'b0);
    beat("st0", 3'b000, 3'b001, 2'd1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall.out_valid", 32'(out_valid),   32'd1);
      check("stall.d0",        32'(out_data[0]), 32'(3'b011));
      check("stall.out_count", 32'(out_count),   32'd1);
      check("stall.out_last",  32'(out_last),    32'd0);
      check("stall.in_ready",  32'(in_ready),    32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    beat("st1", 3'b000, 3'b011, 2'd1, 1'b0);
    beat("st2", 3'b000, 3'b100, 2'd1, 1'b0);
    beat("st3", 3'b000, 3'b010, 2'd1, 1'b1);
    @(negedge clk);
    check_idle("st_done");
    @(posedge clk);
    #1;

    // 6. Reset mid-word, then B single descending
    send_word(word_a, 1'b0, 1'b0);
    beat("rs0", 3'b000, 3'b001, 2'd1, 1'b0);
    @(negedge clk);
    check("rs1.d0", 32'(out_data[0]), 32'(3'b011));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    @(posedge clk);
    #1;
    send_word(word_b, 1'b0, 1'b1);
    beat("sd0", 3'b000, 3'b101, 2'd1, 1'b0);
    beat("sd1", 3'b000, 3'b010, 2'd1, 1'b0);
    beat("sd2", 3'b000, 3'b100, 2'd1, 1'b0);
    beat("sd3", 3'b000, 3'b110, 2'd1, 1'b1);
    @(negedge clk);
    check_idle("sd_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multipack_unpacker
